// File: rtl/q_learning_pkg.sv
// Shared types and constants for the Q-learning accelerator and its step sequencer.
// Holds the sequencer FSM encoding, datapath widths and the LFSR tap mask.
package q_learning_pkg;

  localparam int ACTION_W = 4;
  localparam int STATE_W  = 6;
  localparam int DATA_W   = 16;

  // Right-shifting Fibonacci form of taps 16,14,13,11 -> bits 0,2,3,5.
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    ACT,
    WAIT_ENV,
    UPDATE,
    ADVANCE,
    DONE
  } ctrl_state_e;

endpackage

// File: rtl/q_learning_ctrl_lfsr.sv
// lfsr16: 16-bit Fibonacci LFSR, synchronous active-low reset to seed.
// Ports: clk, rst_n, seed[15:0] (reset value, nonzero), q[15:0] (state).
module lfsr16
  import q_learning_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  logic [15:0] q_q;
  logic [15:0] q_d;

  always_comb begin
    q_d = {^(q_q & LFSR_TAPS), q_q[15:1]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) q_q <= seed;
    else        q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/q_learning_ctrl.sv
// q_learning_ctrl: per-episode step sequencer with epsilon-greedy action choice.
// Ports: start/init_state/epsilon/greedy_action in; act_* and env_* handshakes;
// acc_* accelerator drive; busy, episode_done, step_count, episode_count status.
module q_learning_ctrl
  import q_learning_pkg::*;
#(
  parameter int          NUM_ACTIONS = 15,
  parameter int          ACTION_W    = q_learning_pkg::ACTION_W,
  parameter int          STATE_W     = q_learning_pkg::STATE_W,
  parameter int          DATA_W      = q_learning_pkg::DATA_W,
  parameter int          ACC_LATENCY = 2,
  parameter int          MAX_STEPS   = 64,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [STATE_W-1:0]  init_state,
  input  logic [15:0]         epsilon,
  input  logic [ACTION_W-1:0] greedy_action,
  output logic                act_valid,
  input  logic                act_ready,
  output logic [ACTION_W-1:0] act_out,
  input  logic                env_valid,
  output logic                env_ready,
  input  logic [STATE_W-1:0]  env_next_state,
  input  logic [DATA_W-1:0]   env_reward,
  input  logic                env_terminal,
  output logic                acc_en,
  output logic [ACTION_W-1:0] acc_action,
  output logic [STATE_W-1:0]  acc_state,
  output logic [STATE_W-1:0]  acc_next_state,
  output logic [DATA_W-1:0]   acc_reward,
  output logic                busy,
  output logic                episode_done,
  output logic [7:0]          step_count,
  output logic [15:0]         episode_count
);

  localparam int CNT_W = $clog2(ACC_LATENCY + 1);

  ctrl_state_e         state_q, state_d;
  logic [STATE_W-1:0]  cur_q, cur_d;
  logic [STATE_W-1:0]  nxt_q, nxt_d;
  logic [ACTION_W-1:0] act_q, act_d;
  logic [DATA_W-1:0]   rew_q, rew_d;
  logic                term_q, term_d;
  logic [7:0]          step_q, step_d;
  logic [15:0]         ep_q, ep_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [15:0]         lfsr_q;
  logic [ACTION_W-1:0] rnd_act;
  logic [7:0]          step_inc;

  lfsr16 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .seed  (LFSR_SEED),
    .q     (lfsr_q)
  );

  // Fold out-of-range random codes back into 0..NUM_ACTIONS-1.
  always_comb begin
    rnd_act = lfsr_q[ACTION_W-1:0];
    if (rnd_act >= ACTION_W'(NUM_ACTIONS)) begin
      rnd_act = rnd_act - ACTION_W'(NUM_ACTIONS);
    end
  end

  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    nxt_d    = nxt_q;
    act_d    = act_q;
    rew_d    = rew_q;
    term_d   = term_q;
    step_d   = step_q;
    ep_d     = ep_q;
    cnt_d    = cnt_q;
    step_inc = step_q + 8'd1;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          cur_d   = init_state;
          step_d  = 8'd0;
          state_d = SELECT;
        end
      end
      SELECT: begin
        act_d   = (lfsr_q < epsilon) ? rnd_act : greedy_action;
        state_d = ACT;
      end
      ACT: begin
        if (act_ready) state_d = WAIT_ENV;
      end
      WAIT_ENV: begin
        if (env_valid) begin
          nxt_d   = env_next_state;
          rew_d   = env_reward;
          term_d  = env_terminal;
          cnt_d   = CNT_W'(ACC_LATENCY - 1);
          state_d = UPDATE;
        end
      end
      UPDATE: begin
        if (cnt_q == '0) state_d = ADVANCE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ADVANCE: begin
        cur_d  = nxt_q;
        step_d = step_inc;
        if (term_q || step_inc == 8'(MAX_STEPS)) state_d = DONE;
        else                                     state_d = SELECT;
      end
      DONE: begin
        ep_d    = ep_q + 16'd1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cur_q   <= '0;
      nxt_q   <= '0;
      act_q   <= '0;
      rew_q   <= '0;
      term_q  <= 1'b0;
      step_q  <= '0;
      ep_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      nxt_q   <= nxt_d;
      act_q   <= act_d;
      rew_q   <= rew_d;
      term_q  <= term_d;
      step_q  <= step_d;
      ep_q    <= ep_d;
      cnt_q   <= cnt_d;
    end
  end

  // Handshake strobes drop in the same cycle reset is applied.
  assign act_valid      = rst_n && (state_q == ACT);
  assign env_ready      = rst_n && (state_q == WAIT_ENV);
  assign acc_en         = rst_n && (state_q == UPDATE);
  assign act_out        = act_q;
  assign acc_action     = act_q;
  assign acc_state      = cur_q;
  assign acc_next_state = nxt_q;
  assign acc_reward     = rew_q;
  assign busy           = (state_q != IDLE);
  assign episode_done   = (state_q == DONE);
  assign step_count     = step_q;
  assign episode_count  = ep_q;

endmodule

// File: tb/tb_q_learning_ctrl.sv
// Directed bench for q_learning_ctrl: reset, greedy, terminal, step limit,
// backpressure, mid-update reset and random-action mapping.
module tb_q_learning_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [5:0]  init_state;
  logic [15:0] epsilon;
  logic [3:0]  greedy_action;
  logic        act_valid;
  logic        act_ready;
  logic [3:0]  act_out;
  logic        env_valid;
  logic        env_ready;
  logic [5:0]  env_next_state;
  logic [15:0] env_reward;
  logic        env_terminal;
  logic        acc_en;
  logic [3:0]  acc_action;
  logic [5:0]  acc_state;
  logic [5:0]  acc_next_state;
  logic [15:0] acc_reward;
  logic        busy;
  logic        episode_done;
  logic [7:0]  step_count;
  logic [15:0] episode_count;

  int vectors = 0;
  int miscompares = 0;
  int nib15 = 0;
  int exp_step = 0;
  int exp_ep = 0;
  logic [5:0]  exp_cur;
  logic [15:0] m;
  logic [15:0] m_prev;

  q_learning_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .init_state     (init_state),
    .epsilon        (epsilon),
    .greedy_action  (greedy_action),
    .act_valid      (act_valid),
    .act_ready      (act_ready),
    .act_out        (act_out),
    .env_valid      (env_valid),
    .env_ready      (env_ready),
    .env_next_state (env_next_state),
    .env_reward     (env_reward),
    .env_terminal   (env_terminal),
    .acc_en         (acc_en),
    .acc_action     (acc_action),
    .acc_state      (acc_state),
    .acc_next_state (acc_next_state),
    .acc_reward     (acc_reward),
    .busy           (busy),
    .episode_done   (episode_done),
    .step_count     (step_count),
    .episode_count  (episode_count)
  );

  always #5 clk = ~clk;

  // Reference LFSR: taps 16,14,13,11, shifting right, reset to ACE1.
  always @(posedge clk) begin
    m_prev <= m;
    if (!rst_n) m <= 16'hACE1;
    else        m <= {m[0] ^ m[2] ^ m[3] ^ m[5], m[15:1]};
  end

  function automatic logic [3:0] map_act(input logic [3:0] v);
    return (v >= 4'd15) ? v - 4'd15 : v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_ep(input logic [5:0] init);
    start = 1'b1;
    init_state = init;
    @(negedge clk);
    start = 1'b0;
    chk("start_busy", 32'(busy), 32'd1);
    chk("select_no_valid", 32'(act_valid), 32'd0);
    chk("step_clr", 32'(step_count), 32'd0);
    exp_cur = init;
    exp_step = 0;
  endtask

  task automatic do_step(input logic term, input logic [5:0] ns,
                         input logic [15:0] rw, input int aw,
                         input int ew, input logic exp_done);
    logic [15:0] sel;
    logic [3:0]  ea;
    int n;
    n = 0;
    while (act_valid !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("act_valid", 32'(act_valid), 32'd1);
    chk("act_latency", 32'(n), 32'd1);
    sel = m_prev;
    ea = (sel < epsilon) ? map_act(sel[3:0]) : greedy_action;
    chk("act_out", 32'(act_out), 32'(ea));
    chk("act_range", 32'(act_out < 4'd15), 32'd1);
    if (sel < epsilon && sel[3:0] == 4'hF) begin
      nib15++;
      chk("map15", 32'(act_out), 32'd0);
    end
    for (int i = 0; i < aw; i++) begin
      env_valid = 1'b1;
      env_next_state = ~ns;
      env_reward = ~rw;
      @(negedge clk);
      chk("act_hold_v", 32'(act_valid), 32'd1);
      chk("act_hold", 32'(act_out), 32'(ea));
      chk("bp_no_acc", 32'(acc_en), 32'd0);
    end
    env_valid = 1'b0;
    act_ready = 1'b1;
    @(negedge clk);
    act_ready = 1'b0;
    chk("act_drop", 32'(act_valid), 32'd0);
    chk("env_rdy", 32'(env_ready), 32'd1);
    for (int i = 0; i < ew; i++) begin
      chk("no_acc", 32'(acc_en), 32'd0);
      @(negedge clk);
      chk("env_rdy_hold", 32'(env_ready), 32'd1);
    end
    env_valid = 1'b1;
    env_next_state = ns;
    env_reward = rw;
    env_terminal = term;
    @(negedge clk);
    env_valid = 1'b0;
    env_terminal = 1'b0;
    env_next_state = 6'h2A;
    env_reward = 16'hDEAD;
    for (int i = 0; i < 2; i++) begin
      chk("acc_en", 32'(acc_en), 32'd1);
      chk("acc_action", 32'(acc_action), 32'(ea));
      chk("acc_state", 32'(acc_state), 32'(exp_cur));
      chk("acc_next", 32'(acc_next_state), 32'(ns));
      chk("acc_reward", 32'(acc_reward), 32'(rw));
      @(negedge clk);
    end
    chk("acc_off", 32'(acc_en), 32'd0);
    @(negedge clk);
    exp_cur = ns;
    exp_step++;
    chk("step_count", 32'(step_count), 32'(exp_step));
    chk("episode_done", 32'(episode_done), 32'(exp_done));
  endtask

  task automatic end_ep();
    @(negedge clk);
    exp_ep++;
    chk("idle_busy", 32'(busy), 32'd0);
    chk("done_once", 32'(episode_done), 32'd0);
    chk("ep_count", 32'(episode_count), 32'(exp_ep));
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    init_state = '0;
    epsilon = '0;
    greedy_action = '0;
    act_ready = 1'b0;
    env_valid = 1'b0;
    env_next_state = '0;
    env_reward = '0;
    env_terminal = 1'b0;
    exp_cur = '0;
    repeat (3) @(negedge clk);

    // reset state
    chk("rst_act_valid", 32'(act_valid), 32'd0);
    chk("rst_env_ready", 32'(env_ready), 32'd0);
    chk("rst_acc_en", 32'(acc_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(episode_done), 32'd0);
    chk("rst_act_out", 32'(act_out), 32'd0);
    chk("rst_acc_state", 32'(acc_state), 32'd0);
    chk("rst_acc_reward", 32'(acc_reward), 32'd0);
    chk("rst_step", 32'(step_count), 32'd0);
    chk("rst_ep", 32'(episode_count), 32'd0);
    chk("rst_lfsr", 32'(dut.lfsr_q), 32'hACE1);
    rst_n = 1'b1;
    @(negedge clk);

    // reset on the first acc_en cycle
    epsilon = 16'd0;
    greedy_action = 4'd2;
    start_ep(6'd1);
    @(negedge clk);
    chk("mr_act_valid", 32'(act_valid), 32'd1);
    act_ready = 1'b1;
    @(negedge clk);
    act_ready = 1'b0;
    env_valid = 1'b1;
    env_next_state = 6'd2;
    env_reward = 16'h0055;
    @(negedge clk);
    env_valid = 1'b0;
    chk("mr_acc_en", 32'(acc_en), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mr_acc_drop", 32'(acc_en), 32'd0);
    @(negedge clk);
    chk("mr_acc_en_after", 32'(acc_en), 32'd0);
    chk("mr_idle", 32'(busy), 32'd0);
    chk("mr_ep", 32'(episode_count), 32'd0);
    chk("mr_lfsr", 32'(dut.lfsr_q), 32'hACE1);
    chk("mr_acc_next", 32'(acc_next_state), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // greedy path, start ignored while busy, terminal on step 3
    epsilon = 16'd0;
    greedy_action = 4'd7;
    start_ep(6'd3);
    do_step(1'b0, 6'd5, 16'h0100, 0, 0, 1'b0);
    start = 1'b1;
    init_state = 6'd60;
    do_step(1'b0, 6'd9, 16'h0200, 0, 0, 1'b0);
    start = 1'b0;
    do_step(1'b1, 6'd12, 16'hFFFF, 0, 0, 1'b1);
    chk("term_step", 32'(step_count), 32'd3);
    end_ep();

    // step limit with backpressure on the first step
    greedy_action = 4'd11;
    start_ep(6'd0);
    do_step(1'b0, 6'd33, 16'h1234, 10, 7, 1'b0);
    for (int s = 2; s <= 64; s++) begin
      do_step(1'b0, 6'(s), 16'(s * 7), 0, 0, s == 64);
    end
    chk("limit_step", 32'(step_count), 32'd64);
    end_ep();

    // random selection with epsilon at maximum
    epsilon = 16'hFFFF;
    greedy_action = 4'd3;
    for (int e = 0; e < 16; e++) begin
      start_ep(6'(e));
      for (int s = 1; s <= 64; s++) begin
        do_step(1'b0, 6'(s + e), 16'(s * 3 + e), 0, 0, s == 64);
      end
      end_ep();
    end
    chk("nib15_seen", 32'(nib15 > 0), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
